// File: rtl/axi4_frame_reader.sv
// ---------------------------------------------------------------------------
// axi4_frame_reader
//
// Streams one frame buffer out of memory over an AXI4 read channel and
// presents it as a stream of RGB565 pixels. Each frame is fetched as a series
// of 64-beat INCR bursts of 64-bit words. The beats land in a 128-word FIFO,
// and an unpacker splits each word into four 16-bit pixels, most significant
// pixel first.
//
// Ports
//   clk_100Mhz, rst          single clock, synchronous active-high reset
//   FRAME_BASE_ADDR          frame buffer base, captured on frame_start
//   frame_start              one-cycle request to read one whole frame
//   AR*                      AXI4 read address channel (constant burst attrs)
//   R*                       AXI4 read data channel
//   pixel_data/valid/ready   RGB565 output stream, valid/ready handshake
//   reader_done              one-cycle pulse after the frame's last burst
//   rresp_err                sticky protocol/response error flag
//   state                    current FSM state, for debug
// ---------------------------------------------------------------------------
module axi4_frame_reader #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int FRAME_BYTES    = 153600
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
  input  logic                      frame_start,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [3:0]                ARCACHE,
  output logic [2:0]                ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY,
  output logic [15:0]               pixel_data,
  output logic                      pixel_valid,
  input  logic                      pixel_ready,
  output logic                      reader_done,
  output logic                      rresp_err,
  output logic [1:0]                state
);

  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(512);
  localparam logic [AXI_ADDR_WIDTH-1:0] LAST_OFFSET = AXI_ADDR_WIDTH'(FRAME_BYTES - 512);
  localparam logic [5:0]                LAST_BEAT   = 6'd63;
  localparam logic [7:0]                FIFO_DEPTH  = 8'd128;
  localparam logic [7:0]                BURST_WORDS = 8'd64;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ADDR_SEND  = 2'd1,
    DATA_RECV  = 2'd2,
    WAIT_SPACE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [AXI_ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                      active_q, active_d;
  logic [5:0]                beat_cnt_q, beat_cnt_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic [AXI_DATA_WIDTH-1:0] mem_q [128];
  logic [6:0]                wr_ptr_q, wr_ptr_d;
  logic [6:0]                rd_ptr_q, rd_ptr_d;
  logic [7:0]                count_q, count_d;

  logic [AXI_DATA_WIDTH-1:0] word_q, word_d;
  logic [1:0]                idx_q, idx_d;
  logic                      hold_q, hold_d;

  logic fifo_full;
  logic space_ok;
  logic beat_in;
  logic wr_accept;
  logic fifo_rd;
  logic pix_accept;

  // A burst is only requested when the FIFO can absorb all 64 beats, so the
  // read channel never has to be stalled once the address is out.
  assign fifo_full  = (count_q == FIFO_DEPTH);
  assign space_ok   = ((FIFO_DEPTH - count_q) >= BURST_WORDS);
  assign beat_in    = (state_q == DATA_RECV) && RVALID;
  assign wr_accept  = beat_in && !fifo_full;
  assign pix_accept = hold_q && pixel_ready;

  // Pop when the unpacker is empty, or on the same edge its last pixel is
  // taken, so consecutive words leave without a bubble.
  assign fifo_rd = (count_q != 8'd0) && (!hold_q || (pix_accept && (idx_q == 2'd3)));

  // Read-side control: frame bookkeeping, burst addressing, beat checking.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    offset_d   = offset_q;
    araddr_d   = araddr_q;
    active_d   = active_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (active_q) begin
          if (space_ok) begin
            state_d  = ADDR_SEND;
            araddr_d = base_q + offset_q;
          end else begin
            state_d = WAIT_SPACE;
          end
        end else if (frame_start) begin
          base_d   = FRAME_BASE_ADDR;
          offset_d = '0;
          active_d = 1'b1;
        end
      end
      WAIT_SPACE: begin
        if (space_ok) begin
          state_d  = ADDR_SEND;
          araddr_d = base_q + offset_q;
        end
      end
      ADDR_SEND: begin
        if (ARREADY) begin
          state_d    = DATA_RECV;
          beat_cnt_d = '0;
        end
      end
      DATA_RECV: begin
        if (RVALID) begin
          if (RRESP != 2'b00) begin
            err_d = 1'b1;
          end
          // RLAST always closes the burst, even when the beat count is off;
          // a miscount is only recorded as an error.
          if (RLAST) begin
            if (beat_cnt_q != LAST_BEAT) begin
              err_d = 1'b1;
            end
            beat_cnt_d = '0;
            state_d    = IDLE;
            if (offset_q == LAST_OFFSET) begin
              done_d   = 1'b1;
              active_d = 1'b0;
              offset_d = '0;
            end else begin
              offset_d = offset_q + BURST_BYTES;
            end
          end else begin
            if (beat_cnt_q == LAST_BEAT) begin
              err_d = 1'b1;
            end
            beat_cnt_d = beat_cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat_in && fifo_full) begin
      err_d = 1'b1;
    end
  end

  // FIFO pointers/occupancy and the word-to-pixel unpacker.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    word_d   = word_q;
    idx_d    = idx_q;
    hold_d   = hold_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 7'd1;
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + 7'd1;
    end
    case ({wr_accept, fifo_rd})
      2'b10:   count_d = count_q + 8'd1;
      2'b01:   count_d = count_q - 8'd1;
      default: count_d = count_q;
    endcase

    if (fifo_rd) begin
      word_d = mem_q[rd_ptr_q];
      idx_d  = 2'd0;
      hold_d = 1'b1;
    end else if (pix_accept) begin
      if (idx_q == 2'd3) begin
        hold_d = 1'b0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    pixel_data = word_q[63:48];
      2'd1:    pixel_data = word_q[47:32];
      2'd2:    pixel_data = word_q[31:16];
      default: pixel_data = word_q[15:0];
    endcase
  end

  // State registers; everything returns to its idle value under reset.
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      offset_q   <= '0;
      araddr_q   <= '0;
      active_q   <= 1'b0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      offset_q   <= offset_d;
      araddr_q   <= araddr_d;
      active_q   <= active_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
    end
  end

  // FIFO storage has no reset; the pointers define what is valid.
  always_ff @(posedge clk_100Mhz) begin
    if (!rst && wr_accept) begin
      mem_q[wr_ptr_q] <= RDATA;
    end
  end

  assign ARADDR      = araddr_q;
  assign ARVALID     = (state_q == ADDR_SEND);
  assign RREADY      = (state_q == DATA_RECV);
  assign ARLEN       = 8'd63;
  assign ARSIZE      = 3'b011;
  assign ARBURST     = 2'b01;
  assign ARCACHE     = 4'b0011;
  assign ARPROT      = 3'b000;
  assign pixel_valid = hold_q;
  assign reader_done = done_q;
  assign rresp_err   = err_q;
  assign state       = state_q;

endmodule
